// File: rtl/conv_mac_stream_if.sv
// Streaming handshake bundle for conv_mac_stream: tap input side, result output side.
// The master drives taps and consumes results; the slave is the MAC engine.
interface conv_mac_stream_if #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 9
);
    localparam int IDX_W = $clog2(TAPS);
    localparam int OUT_W = 2 * DATA_W + $clog2(TAPS) + 1;

    logic                       in_valid;
    logic                       in_ready;
    logic signed [DATA_W-1:0]   data_in;
    logic signed [DATA_W-1:0]   weight_in;
    logic signed [2*DATA_W-1:0] bias;
    logic                       clear;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [OUT_W-1:0]    out_data;
    logic [IDX_W-1:0]           tap_idx;

    modport master (
        output in_valid, data_in, weight_in, bias, clear, out_ready,
        input  in_ready, out_valid, out_data, tap_idx
    );

    modport slave (
        input  in_valid, data_in, weight_in, bias, clear, out_ready,
        output in_ready, out_valid, out_data, tap_idx
    );
endinterface

// File: rtl/conv_mac_stream.sv
// Streaming convolution MAC: TAPS signed products per window plus bias into a 2-entry result FIFO.
// Optional macro CONV_MAC_RELU_EN clamps negative results to zero before they enter the FIFO.
module conv_mac_stream #(
    parameter int DATA_W  = 16,
    parameter int TAPS    = 9,
    parameter int MUL_LAT = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    conv_mac_stream_if.slave bus
);
    localparam int IDX_W = $clog2(TAPS);
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = PW + $clog2(TAPS);
    localparam int OUT_W = ACC_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    // wid tells closed windows from the open one so clear can squash only the latter.
    typedef struct packed {
        logic                 vld;
        logic                 first;
        logic                 last;
        logic [2:0]           wid;
        logic signed [PW-1:0] bias;
    } tag_t;

    logic                     run_q;
    logic [IDX_W-1:0]         tap_q;
    logic [2:0]               open_id;
    tag_t                     tag_q    [MUL_LAT+1];
    tag_t                     tag_keep [MUL_LAT+1];
    logic signed [DATA_W-1:0] a_q, b_q;
    logic signed [PW-1:0]     prod_q [MUL_LAT];
    logic signed [ACC_W-1:0]  acc_q, prod_ext;
    logic                     fin_q;
    logic signed [PW-1:0]     fin_bias_q;
    logic signed [OUT_W-1:0]  fifo_q [2];
    logic                     wr_ptr, rd_ptr;
    logic [1:0]               occ_q, infl_q;
    logic [2:0]               used;
    logic                     is_last, accept, push, pop, use_prod, closed_in_pipe;
    logic signed [OUT_W-1:0]  sum_full, res_val;

    assign is_last      = (tap_q == LAST_IDX);
    assign used         = {1'b0, occ_q} + {1'b0, infl_q};
    assign bus.in_ready = run_q && !bus.clear && !(is_last && used >= 3'd2);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = fin_q;
    assign pop          = bus.out_valid && bus.out_ready;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = fifo_q[rd_ptr];
    assign bus.tap_idx   = tap_q;

    // NOTE: combinational blocks use blocking '=' with a default first; clocked blocks use '<=' only.
    always_comb begin
        closed_in_pipe = 1'b0;
        for (int k = 0; k <= MUL_LAT; k++) begin
            tag_keep[k] = tag_q[k];
            if (bus.clear && tag_q[k].wid == open_id) tag_keep[k].vld = 1'b0;
            if (tag_q[k].vld && tag_q[k].wid != open_id) closed_in_pipe = 1'b1;
        end
    end

    assign use_prod = tag_keep[MUL_LAT].vld;
    assign prod_ext = ACC_W'(prod_q[MUL_LAT-1]);
    assign sum_full = OUT_W'(acc_q) + OUT_W'(fin_bias_q);

`ifdef CONV_MAC_RELU_EN
    assign res_val = sum_full[OUT_W-1] ? '0 : sum_full;
`else
    assign res_val = sum_full;
`endif

    // NOTE: the multiplier datapath is left unreset; validity travels in the reset tags.
    always_ff @(posedge clk_in) begin
        a_q       <= bus.data_in;
        b_q       <= bus.weight_in;
        prod_q[0] <= PW'(a_q) * PW'(b_q);
        for (int k = 1; k < MUL_LAT; k++) prod_q[k] <= prod_q[k-1];
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= MUL_LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0].vld   <= accept;
            tag_q[0].first <= (tap_q == '0);
            tag_q[0].last  <= is_last;
            tag_q[0].wid   <= open_id;
            tag_q[0].bias  <= bus.bias;
            for (int k = 1; k <= MUL_LAT; k++) tag_q[k] <= tag_keep[k-1];
        end
    end

    // Accumulator is only zeroed on clear when no closed window still depends on it.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            fin_q      <= 1'b0;
            fin_bias_q <= '0;
        end else begin
            if (use_prod)
                acc_q <= tag_q[MUL_LAT].first ? prod_ext : acc_q + prod_ext;
            else if (bus.clear && !closed_in_pipe)
                acc_q <= '0;
            fin_q      <= use_prod && tag_q[MUL_LAT].last;
            fin_bias_q <= tag_q[MUL_LAT].bias;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            tap_q   <= '0;
            open_id <= '0;
            infl_q  <= '0;
        end else begin
            run_q <= 1'b1;
            if (bus.clear)   tap_q <= '0;
            else if (accept) tap_q <= is_last ? '0 : tap_q + 1'b1;
            if (accept && is_last) open_id <= open_id + 3'd1;
            case ({accept && is_last, push})
                2'b10:   infl_q <= infl_q + 2'd1;
                2'b01:   infl_q <= infl_q - 2'd1;
                default: infl_q <= infl_q;
            endcase
        end
    end

    // NOTE: the FIFO slots are reset so out_data reads zero out of reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ_q     <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= res_val;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_stream.sv
// Self-checking bench for conv_mac_stream: directed corner cases plus randomized traffic
// compared against a window-sum reference model with a result queue.
module tb_conv_mac_stream;
    localparam int DATA_W  = 16;
    localparam int TAPS    = 9;
    localparam int MUL_LAT = 2;
    localparam int PW      = 2 * DATA_W;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    conv_mac_stream_if #(.DATA_W(DATA_W), .TAPS(TAPS)) bus ();

    conv_mac_stream #(.DATA_W(DATA_W), .TAPS(TAPS), .MUL_LAT(MUL_LAT)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: running window sum, pending-result count, expected result queue.
    longint exp_q [$];
    longint m_sum  = 0;
    int     m_tap  = 0;
    int     m_pend = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint post(input longint s);
`ifdef CONV_MAC_RELU_EN
        return (s < 0) ? 0 : s;
`else
        return s;
`endif
    endfunction

    function automatic longint rnd_s(input int bits);
        longint r;
        r = longint'({$urandom, $urandom});
        r = r & ((longint'(1) << bits) - 1);
        if (r >= (longint'(1) << (bits - 1))) r -= (longint'(1) << bits);
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_sum  = 0;
        m_tap  = 0;
        m_pend = 0;
    endtask

    // One cycle: drive at negedge, check against the model, then advance to the next negedge.
    task automatic step(input bit v, input longint d, input longint w, input longint b,
                        input bit clr, input bit ordy, output bit acc);
        bit exp_rdy;
        bus.in_valid  = v;
        bus.data_in   = DATA_W'(d);
        bus.weight_in = DATA_W'(w);
        bus.bias      = PW'(b);
        bus.clear     = clr;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !clr && (m_tap != TAPS - 1 || m_pend < 2);
        check("in_ready", longint'(bus.in_ready), longint'(exp_rdy));
        check("tap_idx", longint'(bus.tap_idx), longint'(m_tap));
        if (exp_q.size() == 0)
            check("out_valid_idle", longint'(bus.out_valid), 0);
        else if (bus.out_valid) begin
            check("out_data", longint'(bus.out_data), exp_q[0]);
            if (ordy) begin
                void'(exp_q.pop_front());
                m_pend--;
            end
        end
        acc = v && exp_rdy;
        if (acc) begin
            m_sum += d * w;
            if (m_tap == TAPS - 1) begin
                exp_q.push_back(post(m_sum + b));
                m_pend++;
                m_sum = 0;
                m_tap = 0;
            end else m_tap++;
        end
        if (clr) begin
            m_sum = 0;
            m_tap = 0;
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic send_window(input longint d, input longint w, input longint b, input bit ordy);
        bit a;
        for (int i = 0; i < TAPS; i++) step(1'b1, d, w, b, 1'b0, ordy, a);
    endtask

    task automatic drain();
        bit a;
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(1'b0, 0, 0, 0, 1'b0, 1'b1, a);
            n++;
        end
        check("drain_left", longint'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  longint'(bus.in_ready), 0);
        check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        check({tag, "_out_data"},  longint'(bus.out_data), 0);
        check({tag, "_tap_idx"},   longint'(bus.tap_idx), 0);
    endtask

    initial begin
        bit a;
        int j;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.weight_in = '0;
        bus.bias      = '0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state and first-edge in_ready rise.
        repeat (3) @(negedge clk_in);
        #1 check_reset_outputs("rst");
        @(negedge clk_in);
        rst_n = 1'b1;
        #1 check("rst_release_in_ready", longint'(bus.in_ready), 0);
        @(negedge clk_in);

        // Ones times two plus bias 5, with latency measurement.
        send_window(1, 2, 5, 1'b1);
        j = 0;
        while (!bus.out_valid && j < 20) begin
            step(1'b0, 0, 0, 0, 1'b0, 1'b1, a);
            j++;
        end
        check("latency", longint'(j), MUL_LAT + 2);
        check("first_result", longint'(bus.out_data), 23);
        drain();

        // Most negative operands: no overflow in the output width.
        send_window(-32768, -32768, 0, 1'b1);
        drain();

        // Back-pressure: two results buffered, third window stalls on its last tap.
        for (int i = 0; i < 40; i++) step(1'b1, 1, 1, 0, 1'b0, 1'b0, a);
        check("bp_tap_idx", longint'(bus.tap_idx), 8);
        check("bp_in_ready", longint'(bus.in_ready), 0);
        check("bp_head", longint'(bus.out_data), 9);
        step(1'b1, 1, 1, 0, 1'b0, 1'b1, a);
        step(1'b1, 1, 1, 0, 1'b0, 1'b0, a);
        check("bp_last_accept", longint'(a), 1);
        drain();

        // Clear after four taps, then a clean window of threes.
        for (int i = 0; i < 4; i++) step(1'b1, 7, 1, 0, 1'b0, 1'b1, a);
        step(1'b1, 7, 1, 0, 1'b1, 1'b1, a);
        send_window(3, 1, 0, 1'b1);
        drain();

        // Negative sum -10 with zero bias.
        step(1'b1, -10, 1, 0, 1'b0, 1'b1, a);
        for (int i = 1; i < TAPS; i++) step(1'b1, 0, 1, 0, 1'b0, 1'b1, a);
        drain();

        // Randomized traffic with bubbles, back-pressure and occasional clear.
        for (int i = 0; i < 800; i++)
            step(($urandom % 4) != 0, rnd_s(DATA_W), rnd_s(DATA_W), rnd_s(PW),
                 ($urandom % 60) == 0, ($urandom % 3) != 0, a);
        drain();

        // Reset mid-window with one result sitting in the FIFO.
        send_window(1, 1, 0, 1'b0);
        j = 0;
        while (!bus.out_valid && j < 20) begin
            step(1'b0, 0, 0, 0, 1'b0, 1'b0, a);
            j++;
        end
        check("pre_reset_valid", longint'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 2, 2, 0, 1'b0, 1'b0, a);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1, a);
        send_window(2, 3, -4, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/conv_mac_stream.md
CONV_MAC_STREAM -- requirements
Module: conv_mac_stream

Interface
REQ-001 Parameter DATA_W, default 16: signed width of feature-map sample and weight.
REQ-002 Parameter TAPS, default 9: products accumulated per output (filter window size), range 2..256.
REQ-003 Parameter MUL_LAT, default 2: pipeline latency of the signed multiplier, range 1..4.
REQ-004 Derived ACC_W = 2*DATA_W + clog2(TAPS); OUT_W = ACC_W + 1.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low. Ports: clk_in (rising edge) and rst_n (active-low, asynchronous assert, synchronous deassert).
REQ-006 clk_in  in  1  system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  data_in/weight_in/bias valid.
REQ-009 in_ready  out  1  tap accepted when in_valid && in_ready at a rising edge.
REQ-010 data_in  in  DATA_W  signed feature-map sample.
REQ-011 weight_in  in  DATA_W  signed weight.
REQ-012 bias  in  2*DATA_W  signed bias; sampled only with the last tap of a window.
REQ-013 clear  in  1  synchronous flush of the partial window.
REQ-014 out_valid  out  1  out_data holds a result.
REQ-015 out_ready  in  1  result consumed when out_valid && out_ready.
REQ-016 out_data  out  OUT_W  signed sum(data*weight) + bias.
REQ-017 tap_idx  out  clog2(TAPS)  index of the next tap to be accepted, 0..TAPS-1.

Function
REQ-018 Each accepted tap SHALL issue a signed product DATA_W x DATA_W -> 2*DATA_W into the MUL_LAT pipeline, with a tag carrying first/last flags.
REQ-019 tap_idx SHALL increment on each accepted tap and wrap from TAPS-1 to 0; the tap accepted at tap_idx==TAPS-1 is the last tap.
REQ-020 Accumulator SHALL load the sign-extended product on a first-tag product and add it on every other product; no truncation or saturation inside ACC_W.
REQ-021 On a last-tag product, the final sum plus the sign-extended bias SHALL be written to a 2-entry result FIFO one cycle later.
REQ-022 Latency: with an empty FIFO, out_valid SHALL rise MUL_LAT+2 cycles after the edge accepting the last tap.
REQ-023 out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head and stay stable while out_valid && !out_ready.
REQ-024 Credits = 2 - (FIFO occupancy + closed windows in flight); in_ready SHALL be low only when tap_idx==TAPS-1 and credits==0; non-last taps are always accepted.
REQ-025 A FIFO pop and a FIFO write in the same cycle SHALL both take effect; a pop SHALL free a credit visible to in_ready the next cycle.
REQ-026 Back-to-back windows with out_ready held high SHALL sustain one tap per cycle with no bubbles.
REQ-027 clear SHALL reset tap_idx to 0, squash all in-flight products of the open window and the accumulator; completed results already in FIFO or in flight SHALL be kept; a tap presented with clear is not accepted (in_ready low that cycle).
REQ-028 in_valid low SHALL stall nothing downstream; in-flight products complete normally.

Reset
REQ-029 On rst_n low: in_ready=0, out_valid=0, out_data=0, tap_idx=0, accumulator, pipeline tags, FIFO and credits cleared.
REQ-030 in_ready SHALL rise on the first edge after rst_n deasserts; reset mid-window discards all partial and buffered results.

Configuration
REQ-031 Macro CONV_MAC_RELU_EN: when defined, the value written to the FIFO SHALL be max(sum+bias, 0); when undefined, the signed sum+bias is written unmodified; latency unchanged in both cases.

Verification
REQ-032 TAPS=9, all data=1, weight=2, bias=5, out_ready=1 -> out_data=23, out_valid exactly MUL_LAT+2 cycles after the 9th accept.
REQ-033 9 taps data=-32768, weight=-32768, bias=0 -> out_data=9663676416 (no overflow in OUT_W=37).
REQ-034 out_ready=0, stream 3 windows of ones/weight 1, bias 0 -> two results of 9 buffered, in_ready low at tap_idx=8 of window 3; one pop -> in_ready high next cycle, third result 9 delivered.
REQ-035 clear asserted after 4 taps, then full window data=3, weight=1, bias=0 -> single result 27, no result from the partial window.
REQ-036 Sum -10, bias 0 -> out_data=0 with CONV_MAC_RELU_EN, -10 without.
REQ-037 rst_n pulsed low at tap 5 with one result in FIFO -> out_valid=0, tap_idx=0, no stale result after reset.
